// File: rtl/bullet_pool.sv
// bullet_pool: multi-slot player projectile engine.
// Launches on fire edges, moves bullets up per tick, retires on hit or top bound.
module bullet_pool #(
    parameter int NUM_BULLETS = 4,
    parameter int SPEED       = 2,
    parameter int BW          = 4,
    parameter int BH          = 9,
    parameter int SPAWN_OFF   = 12,
    parameter int Y_MIN       = 10,
    parameter int FIRE_GAP    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pixpulse,
    input  logic [9:0]             hcount,
    input  logic [9:0]             vcount,
    input  logic                   empty,
    input  logic                   move,
    input  logic                   fire,
    input  logic [9:0]             ship_x,
    input  logic [9:0]             ship_y,
    output logic                   draw_bullet,
    output logic [NUM_BULLETS-1:0] hit_mask,
    output logic                   fire_dropped,
    output logic [3:0]             active_count
);

    localparam int CW = (FIRE_GAP < 1) ? 1 : $clog2(FIRE_GAP + 1);
    localparam int IW = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;

    localparam logic [10:0] BW11      = 11'(BW);
    localparam logic [10:0] BH11      = 11'(BH);
    localparam logic [10:0] YLIM11    = 11'(Y_MIN + SPEED);
    localparam logic [10:0] SPAWN_MIN = 11'(SPAWN_OFF + Y_MIN);

    logic [NUM_BULLETS-1:0] live;
    logic [NUM_BULLETS-1:0] blocked;
    logic [9:0]             xloc [NUM_BULLETS];
    logic [9:0]             yloc [NUM_BULLETS];
    logic [CW-1:0]          cooldown;
    logic                   fire_pend;
    logic                   fire_q;

    logic [10:0]            h11;
    logic [10:0]            v11;
    logic [NUM_BULLETS-1:0] in_x;
    logic [NUM_BULLETS-1:0] in_y;
    logic [NUM_BULLETS-1:0] scan_hit;
    logic [NUM_BULLETS-1:0] live_nxt;
    logic [NUM_BULLETS-1:0] hit_nxt;
    logic [3:0]             cnt_nxt;
    logic [IW-1:0]          free_idx;
    logic                   free_any;
    logic                   tick;
    logic                   fire_edge;
    logic                   spawn_ok;
    logic                   launch;
    logic                   drop;

    assign h11       = {1'b0, hcount};
    assign v11       = {1'b0, vcount};
    assign tick      = pixpulse & move;
    assign fire_edge = pixpulse & fire & ~fire_q;
    assign spawn_ok  = {1'b0, ship_y} >= SPAWN_MIN;
    assign launch    = tick & fire_pend & (cooldown == '0) & free_any & spawn_ok;
    assign drop      = tick & fire_pend & (cooldown == '0) & ~(free_any & spawn_ok);

    // Per-slot box tests (add-only, 11-bit) for drawing and leading-edge scan.
    always_comb begin
        in_x     = '0;
        in_y     = '0;
        scan_hit = '0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            in_x[i] = (h11 + BW11 >= {1'b0, xloc[i]}) &&
                      (h11 <= {1'b0, xloc[i]} + BW11);
            in_y[i] = (v11 + BH11 >= {1'b0, yloc[i]}) &&
                      (v11 <= {1'b0, yloc[i]} + BH11);
            scan_hit[i] = pixpulse & ~empty & live[i] & in_x[i] &
                          (v11 + BH11 + 11'd1 == {1'b0, yloc[i]});
        end
        draw_bullet = |(live & in_x & in_y);
    end

    // Lowest-index slot that is free at the start of this tick.
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
            if (!live[i]) begin
                free_any = 1'b1;
                free_idx = IW'(i);
            end
        end
    end

    // Next liveness: retire on hit (priority) or top bound, then launch.
    always_comb begin
        live_nxt = live;
        hit_nxt  = '0;
        cnt_nxt  = '0;
        if (tick) begin
            for (int i = 0; i < NUM_BULLETS; i++) begin
                if (live[i]) begin
                    if (blocked[i] || scan_hit[i]) begin
                        live_nxt[i] = 1'b0;
                        hit_nxt[i]  = 1'b1;
                    end else if ({1'b0, yloc[i]} < YLIM11) begin
                        live_nxt[i] = 1'b0;
                    end
                end
            end
            if (launch) begin
                live_nxt[free_idx] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_BULLETS; i++) begin
            cnt_nxt = cnt_nxt + 4'(live_nxt[i]);
        end
    end

    // Slot state: liveness, positions and pending collision flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            live    <= '0;
            blocked <= '0;
            for (int i = 0; i < NUM_BULLETS; i++) begin
                xloc[i] <= '0;
                yloc[i] <= '0;
            end
        end else if (pixpulse) begin
            live <= live_nxt;
            if (tick) begin
                blocked <= '0;
                for (int i = 0; i < NUM_BULLETS; i++) begin
                    if (live[i] && live_nxt[i]) begin
                        yloc[i] <= yloc[i] - 10'(SPEED);
                    end
                end
                if (launch) begin
                    xloc[free_idx] <= ship_x;
                    yloc[free_idx] <= ship_y - 10'(SPAWN_OFF);
                end
            end else begin
                blocked <= blocked | scan_hit;
            end
        end
    end

    // Fire edge capture and cooldown; a new edge outranks a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            fire_q    <= 1'b0;
            fire_pend <= 1'b0;
            cooldown  <= '0;
        end else if (pixpulse) begin
            fire_q <= fire;
            if (tick && cooldown != '0) begin
                cooldown <= cooldown - 1'b1;
            end
            if (launch) begin
                cooldown <= CW'(FIRE_GAP);
            end
            if (launch || drop) begin
                fire_pend <= 1'b0;
            end
            if (fire_edge) begin
                fire_pend <= 1'b1;
            end
        end
    end

    // Registered status: one-clk pulses and live count at each move tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_mask     <= '0;
            fire_dropped <= 1'b0;
            active_count <= '0;
        end else begin
            hit_mask     <= hit_nxt;
            fire_dropped <= drop;
            if (tick) begin
                active_count <= cnt_nxt;
            end
        end
    end

endmodule

// File: tb/tb_bullet_pool.sv
// tb_bullet_pool: directed and random stimulus for bullet_pool,
// checked every cycle against a behavioural model.
module tb_bullet_pool;

    localparam int NB        = 4;
    localparam int SPEED     = 2;
    localparam int BW        = 4;
    localparam int BH        = 9;
    localparam int SPAWN_OFF = 12;
    localparam int Y_MIN     = 10;
    localparam int FIRE_GAP  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pixpulse = 1'b0;
    logic [9:0]    hcount = '0;
    logic [9:0]    vcount = '0;
    logic          empty = 1'b1;
    logic          move = 1'b0;
    logic          fire = 1'b0;
    logic [9:0]    ship_x = '0;
    logic [9:0]    ship_y = '0;
    logic          draw_bullet;
    logic [NB-1:0] hit_mask;
    logic          fire_dropped;
    logic [3:0]    active_count;

    bullet_pool #(
        .NUM_BULLETS(NB), .SPEED(SPEED), .BW(BW), .BH(BH),
        .SPAWN_OFF(SPAWN_OFF), .Y_MIN(Y_MIN), .FIRE_GAP(FIRE_GAP)
    ) dut (
        .clk(clk), .rst(rst), .pixpulse(pixpulse),
        .hcount(hcount), .vcount(vcount), .empty(empty),
        .move(move), .fire(fire), .ship_x(ship_x), .ship_y(ship_y),
        .draw_bullet(draw_bullet), .hit_mask(hit_mask),
        .fire_dropped(fire_dropped), .active_count(active_count)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    bit [NB-1:0] m_live;
    bit [NB-1:0] m_blk;
    int          m_x [NB];
    int          m_y [NB];
    int          m_cd;
    bit          m_pend;
    bit          m_prev;
    bit [NB-1:0] m_hit;
    bit          m_drop;
    int          m_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_on = 0;

    function automatic int iabs(int a);
        return (a < 0) ? -a : a;
    endfunction

    function automatic bit model_draw();
        bit d = 0;
        for (int i = 0; i < NB; i++)
            if (m_live[i] && iabs(int'(hcount) - m_x[i]) <= BW &&
                iabs(int'(vcount) - m_y[i]) <= BH)
                d = 1;
        return d;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // One clock of the model, using the inputs held over that clock.
    task automatic model_step();
        bit [NB-1:0] sh;
        bit [NB-1:0] free0;
        bit          edge_f;
        int          lo;
        m_hit  = '0;
        m_drop = 0;
        if (rst) begin
            m_live = '0; m_blk = '0; m_cd = 0; m_pend = 0; m_prev = 0; m_cnt = 0;
            for (int i = 0; i < NB; i++) begin m_x[i] = 0; m_y[i] = 0; end
            return;
        end
        if (!pixpulse) return;
        edge_f = fire && !m_prev;
        m_prev = fire;
        sh = '0;
        for (int i = 0; i < NB; i++)
            if (m_live[i] && !empty && int'(vcount) == m_y[i] - BH - 1 &&
                iabs(int'(hcount) - m_x[i]) <= BW)
                sh[i] = 1;
        if (move) begin
            free0 = ~m_live;
            for (int i = 0; i < NB; i++) begin
                if (m_live[i]) begin
                    if (m_blk[i] || sh[i]) begin m_live[i] = 0; m_hit[i] = 1; end
                    else if (m_y[i] < Y_MIN + SPEED) m_live[i] = 0;
                    else m_y[i] = m_y[i] - SPEED;
                end
            end
            m_blk = '0;
            lo = -1;
            for (int i = NB - 1; i >= 0; i--) if (free0[i]) lo = i;
            if (m_cd > 0) m_cd--;
            else if (m_pend) begin
                if (int'(ship_y) >= SPAWN_OFF + Y_MIN && lo >= 0) begin
                    m_live[lo] = 1;
                    m_x[lo] = int'(ship_x);
                    m_y[lo] = int'(ship_y) - SPAWN_OFF;
                    m_cd = FIRE_GAP;
                end else m_drop = 1;
                m_pend = 0;
            end
            m_cnt = $countones(m_live);
        end else m_blk |= sh;
        if (edge_f) m_pend = 1;
    endtask

    // Compare process: every output against the model, away from the edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("draw_bullet", int'(draw_bullet), int'(model_draw()));
            chk("hit_mask", int'(hit_mask), int'(m_hit));
            chk("fire_dropped", int'(fire_dropped), int'(m_drop));
            chk("active_count", int'(active_count), m_cnt);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1 model_step();
    endtask

    task automatic step(bit mv);
        pixpulse = 1;
        move = mv;
        cyc();
        move = 0;
    endtask

    task automatic do_reset();
        rst = 1; step(0); step(0); rst = 0;
    endtask

    task automatic shoot();
        fire = 1; step(0); step(1); fire = 0; step(0);
    endtask

    initial begin
        int j;
        int hv;
        // Reset then idle
        rst = 1; cyc(); chk_on = 1; cyc();
        chk("reset active_count", int'(active_count), 0);
        chk("reset hit_mask", int'(hit_mask), 0);
        rst = 0;
        for (int i = 0; i < 100; i++) begin
            hcount = 10'($urandom_range(0, 1023));
            vcount = 10'($urandom_range(0, 1023));
            step(1);
        end
        chk("idle active_count", int'(active_count), 0);

        // Single shot from (320,240)
        ship_x = 320; ship_y = 240;
        shoot();
        chk("shot count", int'(active_count), 1);
        chk("model spawn y", m_y[0], 228);
        chk("model spawn x", m_x[0], 320);
        for (int i = 0; i < 5; i++) step(1);
        chk("model y after 5", m_y[0], 218);
        hcount = 324; vcount = 227; #1;
        chk("draw 324,227", int'(draw_bullet), 1);
        hcount = 325; vcount = 218; #1;
        chk("draw 325,218", int'(draw_bullet), 0);

        // Fill the pool at the cooldown rate, then overflow
        do_reset();
        for (int k = 0; k < NB; k++) begin
            fire = 1; step(0); step(1); fire = 0;
            for (int t = 0; t < FIRE_GAP; t++) step(1);
        end
        chk("pool full count", int'(active_count), 4);
        fire = 1; step(0); step(1); fire = 0;
        chk("overflow dropped", int'(fire_dropped), 1);
        chk("overflow count", int'(active_count), 4);
        step(0);
        chk("dropped one clk", int'(fire_dropped), 0);

        // Collision on the leading edge
        do_reset();
        ship_x = 100; ship_y = 162;
        shoot();
        hcount = 102; vcount = 140; empty = 0; step(0);
        empty = 1; step(0); step(1);
        chk("collision hit_mask", int'(hit_mask), 1);
        chk("collision count", int'(active_count), 0);
        hcount = 100; vcount = 150; #1;
        chk("collision no draw", int'(draw_bullet), 0);

        // Top bound retire
        do_reset();
        ship_x = 300; ship_y = 23;
        shoot();
        chk("bound spawn count", int'(active_count), 1);
        step(1);
        chk("bound hit_mask", int'(hit_mask), 0);
        chk("bound count", int'(active_count), 0);

        // Left edge: no wrap to the far right
        do_reset();
        ship_x = 2; ship_y = 240;
        shoot();
        vcount = 228;
        for (int h = 0; h < 1024; h++) begin
            hcount = 10'(h); #1;
            if (h <= 6 || h >= 1020)
                chk("edge draw", int'(draw_bullet), (h <= 6) ? 1 : 0);
            step(0);
        end
        hcount = 2;
        rst = 1; step(0); rst = 0;
        chk("midflight rst count", int'(active_count), 0);
        chk("midflight rst draw", int'(draw_bullet), 0);

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 599) == 0);
            pixpulse = ($urandom_range(0, 3) != 0);
            move = pixpulse && ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 5) == 0) fire = ~fire;
            empty = ($urandom_range(0, 9) != 0);
            ship_x = 10'($urandom_range(0, 639));
            ship_y = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 30))
                                                 : 10'($urandom_range(100, 479));
            j = $urandom_range(0, NB - 1);
            if ($urandom_range(0, 1) == 0 && m_live[j] && m_y[j] > BH) begin
                vcount = 10'(m_y[j] - BH - 1);
                hv = m_x[j] + int'($urandom_range(0, 12)) - 6;
                hcount = 10'((hv < 0) ? 0 : hv);
            end else begin
                hcount = 10'($urandom_range(0, 1023));
                vcount = 10'($urandom_range(0, 1023));
            end
            cyc();
            move = 0;
        end
        rst = 0;
        step(0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bullet_pool.md
# bullet_pool

Multi-slot projectile engine for the player ship: holds up to NUM_BULLETS independent bullets and launches one per fire press from the ship position. It moves all live bullets upward on each move tick, retires them on collision or at the top bound, and drives a combined draw signal into the pixel mux. It sits between the button debouncer and ship position logic on one side and the VGA pixel pipeline on the other. It replaces the single-bullet block and adds per-slot tracking, fire cooldown and hit reporting.

## Interface
- NUM_BULLETS, 4: number of bullet slots (1..8).
- SPEED, 2: pixels moved upward per move tick.
- BW, 4: half-width of the bullet box in pixels.
- BH, 9: half-height of the bullet box in pixels.
- SPAWN_OFF, 12: spawn yloc = ship_y − SPAWN_OFF.
- Y_MIN, 10: a bullet whose yloc < Y_MIN + SPEED at a move tick is retired.
- FIRE_GAP, 8: cooldown, in move ticks, after a launch.

- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- pixpulse  in  1  pixel-rate enable; all state advances only when high.
- hcount  in  10  current pixel column.
- vcount  in  10  current pixel row.
- empty  in  1  high when the non-bullet layers are background at (hcount, vcount).
- move  in  1  frame move tick, qualified by pixpulse.
- fire  in  1  debounced fire button level.
- ship_x  in  10  ship centre x.
- ship_y  in  10  ship centre y.
- draw_bullet  out  1  combinational; high when the pixel lies inside any live bullet box.
- hit_mask  out  NUM_BULLETS  one-cycle pulse; bit i set when slot i was retired by a collision.
- fire_dropped  out  1  one-cycle pulse when a pending fire is discarded.
- active_count  out  4  number of live slots.

## Operation
- Per slot i: live[i], xloc[i][9:0], yloc[i][9:0], blocked[i].
- Fire edge detection:
  - fire is sampled on pixpulse.
  - A 0→1 transition sets fire_pend.
  - Further edges while fire_pend is set are ignored.
- Collision scan, on each pixpulse with ~empty, for each live slot:
  - Condition: vcount == yloc−BH−1 and hcount is within [xloc−BW, xloc+BW].
  - Action: set blocked[i].
  - Only the leading (top) edge is scanned.
- Move tick (pixpulse & move). Evaluate each live slot in this priority:
  1. blocked[i]: clear live[i]; pulse hit_mask[i].
  2. Else yloc[i] < Y_MIN+SPEED: clear live[i]; no hit.
  3. Else yloc[i] −= SPEED.
- Also on the move tick:
  - Clear all blocked[].
  - If cooldown ≠ 0, decrement cooldown.
- Launch, on a move tick with fire_pend set:
  - If cooldown == 0 and any slot was free at the start of the tick:
    - Load the lowest-index free slot with xloc = ship_x and yloc = ship_y − SPAWN_OFF.
    - Set live.
    - Set cooldown = FIRE_GAP.
    - Clear fire_pend.
  - If cooldown == 0 and all slots are live: pulse fire_dropped and clear fire_pend.
  - If cooldown ≠ 0: fire_pend stays set.
- Reuse rule: a slot freed on a tick is not reusable until the next tick.
- If ship_y < SPAWN_OFF + Y_MIN, the launch is dropped with fire_dropped; no wrap-around spawn.
- Arithmetic: all box and bound comparisons use 11-bit zero-extended values, rearranged to add only (e.g. hcount+BW ≥ xloc), so a bullet near x=0 or y=0 never wraps.
- Draw condition: draw_bullet = OR over i of live[i] & (|hcount−xloc[i]| ≤ BW) & (|vcount−yloc[i]| ≤ BH).

## Timing
- Reset values:
  - live = 0, blocked = 0, xloc = 0, yloc = 0.
  - cooldown = 0, fire_pend = 0.
  - hit_mask = 0, fire_dropped = 0, active_count = 0.
  - draw_bullet = 0.
- An asserted rst mid-flight kills all bullets on that clk edge.
- hit_mask, fire_dropped and active_count are registered. They update on the clk edge of the move-tick pixpulse; the pulses last exactly one clk.
- Launch latency: the bullet is live and drawable from the first clk after the first qualifying move tick following the fire edge.
- Simultaneous events:
  - A collision and the bound check in the same tick count as a hit.
  - A fire edge on the same pixpulse as a move tick is registered and launches on the next move tick.
- A collision seen after the last scanned line of a frame is acted on at the next move tick.

## Test plan
- Reset then idle: rst high 2 clk, 100 move ticks → active_count=0, draw_bullet never high, no pulses.
- Single shot: ship (320,240), one fire edge, move tick → slot0 at (320,228). After 5 more ticks yloc=218. draw_bullet high at (324,227) and low at (325,218).
- Cooldown and full pool (NUM_BULLETS=4, FIRE_GAP=8):
  - Fire edges every 9 ticks → slots 0..3 fill in order, active_count=4.
  - 5th edge → fire_dropped pulse, count stays 4.
- Collision: bullet at (100,150), empty=0 at (102,140) in the scan frame → next move tick pulses hit_mask=0001 and live[0]=0. Bullet pixels at (100,150) are not drawn in the following frame.
- Top bound: bullet at yloc=11, SPEED=2, Y_MIN=10 → retired at next tick, hit_mask=0, active_count decrements.
- Edge wrap: ship_x=2, BW=4 → bullet drawn on hcount 0..6 only, never at hcount 1020..1023. rst asserted mid-flight clears all slots on the next clk.
